// File: rtl/ru_dispatch_ctrl.sv
// ============================================================================
// Module  : ru_dispatch_ctrl
// Purpose : Recompute-unit (RU) dispatch controller for BISR of a ROWSxCOLS
//           systolic array. On start it latches the PE fault map and assigns
//           up to NUM_RU faulty PEs to RU slots (one map index per cycle).
//           It then raster-fills the data buffer from an operand stream and
//           presents each assigned PE's buffered operand to its RU over a
//           valid/ready handshake.
// Ports   : clk, rst_n            clock, async active-low reset
//           start, fault_map      pass request and PE fault map (bit r*COLS+c)
//           in_valid/in_data/in_ready   operand stream, raster order
//           buf_we/buf_row/buf_col/buf_wdata   data_buffer write port
//           rd_row/rd_col         per-RU buffer read addresses (slot-packed)
//           ru_valid/ru_ready     per-RU operand handshake
//           ru_assigned           slot holds a faulty PE
//           busy/done/overflow    status; overflow sticky until next start
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ru_dispatch_ctrl #(
    parameter int ROWS      = 3,
    parameter int COLS      = 3,
    parameter int WORD_SIZE = 16,
    parameter int NUM_RU    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ROWS*COLS-1:0]   fault_map,
    input  logic                   in_valid,
    input  logic [WORD_SIZE-1:0]   in_data,
    output logic                   in_ready,
    output logic                   buf_we,
    output logic [ROWS-1:0]        buf_row,
    output logic [COLS-1:0]        buf_col,
    output logic [WORD_SIZE-1:0]   buf_wdata,
    output logic [NUM_RU*ROWS-1:0] rd_row,
    output logic [NUM_RU*COLS-1:0] rd_col,
    output logic [NUM_RU-1:0]      ru_valid,
    input  logic [NUM_RU-1:0]      ru_ready,
    output logic [NUM_RU-1:0]      ru_assigned,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int NPE = ROWS * COLS;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ALLOC    = 3'd1;
    localparam logic [2:0] S_FILL     = 3'd2;
    localparam logic [2:0] S_DISPATCH = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [ROWS-1:0] C_LAST_ROW = ROWS'(ROWS - 1);
    localparam logic [COLS-1:0] C_LAST_COL = COLS'(COLS - 1);

    logic [2:0]          state_q, state_d;
    logic [NPE-1:0]      map_q, map_d;
    logic [ROWS-1:0]     row_q, row_d, row_nxt;
    logic [COLS-1:0]     col_q, col_d, col_nxt;
    logic [ROWS-1:0]     slot_row_q [NUM_RU];
    logic [ROWS-1:0]     slot_row_d [NUM_RU];
    logic [COLS-1:0]     slot_col_q [NUM_RU];
    logic [COLS-1:0]     slot_col_d [NUM_RU];
    logic [NUM_RU-1:0]   assigned_q, assigned_d;
    logic [NUM_RU-1:0]   pend_q, pend_d;
    logic [NUM_RU-1:0]   valid_q, valid_d;
    logic                ovf_q, ovf_d;
    logic                last_pos;
    logic [NUM_RU-1:0]   free_oh;
    logic [NUM_RU-1:0]   hs;

    // The raster counter serves both the ALLOC scan and the FILL write address.
    assign last_pos = (row_q == C_LAST_ROW) && (col_q == C_LAST_COL);
    // Lowest clear bit of the assignment vector, one-hot (zero when full).
    assign free_oh  = ~assigned_q & (assigned_q + 1'b1);
    assign hs       = valid_q & ru_ready;

    always_comb begin
        row_nxt = row_q;
        col_nxt = col_q + 1'b1;
        if (col_q == C_LAST_COL) begin
            col_nxt = '0;
            row_nxt = last_pos ? '0 : row_q + 1'b1;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            assigned_q <= '0;
            pend_q     <= '0;
            valid_q    <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < NUM_RU; i++) begin
                slot_row_q[i] <= '0;
                slot_col_q[i] <= '0;
            end
        end else begin
            map_q      <= map_d;
            row_q      <= row_d;
            col_q      <= col_d;
            assigned_q <= assigned_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            slot_row_q <= slot_row_d;
            slot_col_q <= slot_col_d;
        end
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        map_d      = map_q;
        row_d      = row_q;
        col_d      = col_q;
        assigned_d = assigned_q;
        pend_d     = pend_q;
        valid_d    = '0;
        ovf_d      = ovf_q;
        slot_row_d = slot_row_q;
        slot_col_d = slot_col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    map_d      = fault_map;
                    row_d      = '0;
                    col_d      = '0;
                    assigned_d = '0;
                    pend_d     = '0;
                    ovf_d      = 1'b0;
                    for (int i = 0; i < NUM_RU; i++) begin
                        slot_row_d[i] = '0;
                        slot_col_d[i] = '0;
                    end
                end
            end
            S_ALLOC: begin
                // Map is consumed LSB-first so bit 0 is always the index under scan.
                map_d = map_q >> 1;
                row_d = row_nxt;
                col_d = col_nxt;
                if (map_q[0]) begin
                    if (free_oh == '0) begin
                        ovf_d = 1'b1;
                    end else begin
                        assigned_d = assigned_q | free_oh;
                        for (int i = 0; i < NUM_RU; i++) begin
                            if (free_oh[i]) begin
                                slot_row_d[i] = row_q;
                                slot_col_d[i] = col_q;
                            end
                        end
                    end
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    row_d = row_nxt;
                    col_d = col_nxt;
                    if (last_pos) pend_d = assigned_q;
                end
            end
            S_DISPATCH: begin
                // valid_q lags pend_q by the one-cycle buffer read latency on entry.
                pend_d  = pend_q & ~hs;
                valid_d = pend_q & ~hs;
            end
            default: ;
        endcase
    end

    // ---------------- FSM next-state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_ALLOC;
            S_ALLOC:    if (last_pos) state_d = (assigned_d == '0) ? S_DONE : S_FILL;
            S_FILL:     if (in_valid && last_pos) state_d = S_DISPATCH;
            S_DISPATCH: if (pend_d == '0) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        in_ready    = (state_q == S_FILL);
        buf_we      = in_valid && (state_q == S_FILL);
        buf_row     = (state_q == S_FILL) ? row_q : '0;
        buf_col     = (state_q == S_FILL) ? col_q : '0;
        buf_wdata   = (state_q == S_FILL) ? in_data : '0;
        rd_row      = '0;
        rd_col      = '0;
        for (int i = 0; i < NUM_RU; i++) begin
            if ((state_q == S_DISPATCH) && assigned_q[i]) begin
                rd_row[i*ROWS +: ROWS] = slot_row_q[i];
                rd_col[i*COLS +: COLS] = slot_col_q[i];
            end
        end
        ru_valid    = valid_q;
        ru_assigned = assigned_q;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        overflow    = ovf_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_ru_dispatch_ctrl.sv
// ============================================================================
// Module  : tb_ru_dispatch_ctrl
// Purpose : Scoreboard bench for ru_dispatch_ctrl. Stimulus tasks push the
//           expected buffer writes, per-slot operands and end-of-pass status;
//           a negedge monitor pops and compares as the DUT presents them.
//           A behavioural data_buffer (1-cycle read latency) supplies q_data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ru_dispatch_ctrl;

    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int WS   = 16;
    localparam int NRU  = 3;
    localparam int NPE  = ROWS * COLS;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [NPE-1:0]       fault_map;
    logic                 in_valid;
    logic [WS-1:0]        in_data;
    logic                 in_ready;
    logic                 buf_we;
    logic [ROWS-1:0]      buf_row;
    logic [COLS-1:0]      buf_col;
    logic [WS-1:0]        buf_wdata;
    logic [NRU*ROWS-1:0]  rd_row;
    logic [NRU*COLS-1:0]  rd_col;
    logic [NRU-1:0]       ru_valid;
    logic [NRU-1:0]       ru_ready;
    logic [NRU-1:0]       ru_assigned;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    always #5 clk = ~clk;

    ru_dispatch_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .NUM_RU(NRU)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fault_map(fault_map),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .buf_we(buf_we), .buf_row(buf_row), .buf_col(buf_col), .buf_wdata(buf_wdata),
        .rd_row(rd_row), .rd_col(rd_col), .ru_valid(ru_valid), .ru_ready(ru_ready),
        .ru_assigned(ru_assigned), .busy(busy), .done(done), .overflow(overflow)
    );

    logic [50:0] all_out;
    assign all_out = {in_ready, buf_we, buf_row, buf_col, buf_wdata, rd_row, rd_col,
                      ru_valid, ru_assigned, busy, done, overflow};

    // ---------------- data_buffer model ----------------
    logic [WS-1:0] mem [0:7][0:7];
    logic [WS-1:0] q_data [NRU];
    always @(posedge clk) begin
        if (buf_we) mem[buf_row][buf_col] <= buf_wdata;
        for (int i = 0; i < NRU; i++)
            q_data[i] <= mem[rd_row[i*ROWS +: ROWS]][rd_col[i*COLS +: COLS]];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [ROWS-1:0] row;
        logic [COLS-1:0] col;
        logic [WS-1:0]   data;
    } wr_t;
    typedef struct {
        logic [NRU-1:0] asg;
        logic           ovf;
        int             nbusy;
        int             nrdy;
        int             nwr;
    } pass_t;

    wr_t           wr_q[$];
    pass_t         pass_q[$];
    logic [WS-1:0] s0_q[$];
    logic [WS-1:0] s1_q[$];
    logic [WS-1:0] s2_q[$];

    int nerr = 0, nchk = 0;
    int cyc = 0, busy_cnt = 0, rdy_cnt = 0, wr_cnt = 0, last_wr_cyc = 0, done_cnt = 0;
    bit first_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic int slot_size(input int i);
        case (i)
            0:       return s0_q.size();
            1:       return s1_q.size();
            default: return s2_q.size();
        endcase
    endfunction

    function automatic logic [WS-1:0] slot_pop(input int i);
        case (i)
            0:       return s0_q.pop_front();
            1:       return s1_q.pop_front();
            default: return s2_q.pop_front();
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        wr_t   w;
        pass_t p;
        cyc++;
        if (!rst_n) begin
            busy_cnt   = 0;
            rdy_cnt    = 0;
            wr_cnt     = 0;
            first_seen = 1'b0;
        end else begin
            if (busy)     busy_cnt++;
            if (in_ready) rdy_cnt++;
            if (buf_we) begin
                if (wr_q.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 64'({buf_row, buf_col}), 64'({w.row, w.col}));
                    chk("wr_data", 64'(buf_wdata), 64'(w.data));
                end
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if ((|ru_valid) && !first_seen) begin
                first_seen = 1'b1;
                chk("valid_latency_after_last_write", 64'(cyc - last_wr_cyc), 64'(2));
            end
            for (int i = 0; i < NRU; i++) begin
                if (ru_valid[i] && ru_ready[i]) begin
                    if (slot_size(i) == 0) fail($sformatf("unexpected_handshake_slot%0d", i));
                    else chk($sformatf("slot%0d_q_data", i), 64'(q_data[i]), 64'(slot_pop(i)));
                end
            end
            if (done) begin
                done_cnt++;
                if (pass_q.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    p = pass_q.pop_front();
                    chk("done_assigned", 64'(ru_assigned), 64'(p.asg));
                    chk("done_overflow", 64'(overflow), 64'(p.ovf));
                    chk("done_write_count", 64'(wr_cnt), 64'(p.nwr));
                    chk("done_valid_low", 64'(ru_valid), 64'(0));
                    chk("done_slots_drained", 64'(s0_q.size() + s1_q.size() + s2_q.size()), 64'(0));
                    if (p.nbusy >= 0) chk("busy_cycles", 64'(busy_cnt), 64'(p.nbusy));
                    if (p.nrdy >= 0)  chk("in_ready_cycles", 64'(rdy_cnt), 64'(p.nrdy));
                end
                busy_cnt   = 0;
                rdy_cnt    = 0;
                wr_cnt     = 0;
                first_seen = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_pass(
        input logic [NPE-1:0] map, input logic [WS-1:0] base,
        input bit do_fill, input bit stall, input bit glitch,
        input int d0, input int d1, input int d2,
        input logic [NRU-1:0] easg, input logic eovf,
        input logic [WS-1:0] e0, input logic [WS-1:0] e1, input logic [WS-1:0] e2,
        input int ebusy, input int enrdy);
        int    dly [NRU];
        int    k, c, dc;
        wr_t   w;
        pass_t p;
        dly = '{d0, d1, d2};
        if (do_fill) begin
            for (int j = 0; j < NPE; j++) begin
                w.row  = ROWS'(j / COLS);
                w.col  = COLS'(j % COLS);
                w.data = base + WS'(j);
                wr_q.push_back(w);
            end
        end
        if (easg[0]) s0_q.push_back(e0);
        if (easg[1]) s1_q.push_back(e1);
        if (easg[2]) s2_q.push_back(e2);
        p = '{easg, eovf, ebusy, enrdy, (do_fill ? NPE : 0)};
        pass_q.push_back(p);

        for (int i = 0; i < NRU; i++) ru_ready[i] = (dly[i] == 0);
        fault_map = map;
        start     = 1'b1;
        in_valid  = !do_fill;   // a zero-fault pass keeps valid high: nothing may be written
        in_data   = base;
        @(posedge clk); #1;
        start = 1'b0;

        if (do_fill) begin
            k = 0;
            c = 0;
            while (k < NPE && c < 400) begin
                start = glitch && (c == 3);
                if (glitch && (c == 3)) fault_map = '1;
                in_valid = stall ? c[0] : 1'b1;
                in_data  = base + WS'(k);
                @(negedge clk);
                if (in_valid && in_ready) k++;
                @(posedge clk); #1;
                c++;
            end
            start    = 1'b0;
            in_valid = 1'b0;
            if (k < NPE) fail("stream_timeout");
        end

        c  = 0;
        dc = done_cnt;
        while (done_cnt == dc && c < 200) begin
            for (int i = 0; i < NRU; i++) ru_ready[i] = (c >= dly[i]);
            @(posedge clk); #1;
            c++;
        end
        if (done_cnt == dc) fail("done_timeout");
        ru_ready = '0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("hold_after_done", 64'({ru_assigned, overflow, busy, done}), 64'({easg, eovf, 2'b00}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, c;
        wr_t w;
        rst_n     = 1'b0;
        start     = 1'b0;
        fault_map = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        ru_ready  = '0;
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", 64'(all_out), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single fault at (1,1)
        run_pass(9'b000010000, 16'h0000, 1, 0, 0, 0, 0, 0,
                 3'b001, 1'b0, 16'd4, 16'd0, 16'd0, 21, 9);
        // 2: faults at 0,4,8
        run_pass(9'b100010001, 16'h0000, 1, 0, 0, 0, 0, 0,
                 3'b111, 1'b0, 16'd0, 16'd4, 16'd8, 21, 9);
        // 3: faults at 1,2,3,5 -> index 5 dropped
        run_pass(9'b000101110, 16'h0000, 1, 0, 0, 0, 0, 0,
                 3'b111, 1'b1, 16'd1, 16'd2, 16'd3, 21, 9);
        // 4: no faults -> ALLOC then DONE, overflow cleared
        run_pass(9'b000000000, 16'h0000, 0, 0, 0, 0, 0, 0,
                 3'b000, 1'b0, 16'd0, 16'd0, 16'd0, 10, 0);
        // 5: stalling stream, staggered RU readiness
        run_pass(9'b100010001, 16'h00A0, 1, 1, 0, 3, 0, 6,
                 3'b111, 1'b0, 16'h00A0, 16'h00A4, 16'h00A8, -1, -1);

        // 6: reset mid-FILL after three words
        for (int j = 0; j < 3; j++) begin
            w.row  = '0;
            w.col  = COLS'(j);
            w.data = 16'h0070 + WS'(j);
            wr_q.push_back(w);
        end
        ru_ready  = '1;
        fault_map = 9'b000010000;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0070;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        c = 0;
        while (k < 3 && c < 100) begin
            in_data = 16'h0070 + WS'(k);
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
            c++;
        end
        if (k < 3) fail("partial_stream_timeout");
        in_data = 16'h007F;
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 64'(all_out), 64'(0));
        @(posedge clk); #1;
        chk("reset_held_outputs", 64'(all_out), 64'(0));
        in_valid = 1'b0;
        ru_ready = '0;
        @(negedge clk) rst_n = 1'b1;
        chk("aborted_writes_drained", 64'(wr_q.size()), 64'(0));
        @(posedge clk); #1;
        // clean pass with a start pulse while busy (must be ignored)
        run_pass(9'b001000000, 16'h0050, 1, 0, 1, 0, 0, 0,
                 3'b001, 1'b0, 16'h0056, 16'd0, 16'd0, 21, 9);

        repeat (3) @(posedge clk);
        chk("pending_expectations", 64'(wr_q.size() + pass_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
